// File: rtl/hynoc_local_packetizer.sv
// hynoc_local_packetizer
//   Client-side packet builder feeding the HyNoC local ingress port. A packet
//   command (route, payload length) is turned into one header flit followed
//   by `length` payload flits taken from the payload word stream. The top
//   bit of every flit is the tail flag.
//
// Ports:
//   clk, arstn                   clock, asynchronous active-low reset
//   cmd_valid/ready/route/length packet command handshake
//   pld_valid/ready/data         payload word stream
//   local_ingress_write/data     flit write toward the local interface
//   local_ingress_full           ingress FIFO full (blocks writes)
//   busy                         high while a packet is in progress
//   pkt_count, flit_count        statistics counters
//
// Build option:
//   HYNOC_PACKETIZER_STATS_EN    when defined, pkt_count/flit_count count
//                                completed packets / written flits; when
//                                undefined, both are tied to 0.
module hynoc_local_packetizer #(
  parameter int FLIT_WIDTH  = 33,
  parameter int ROUTE_WIDTH = 16,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ROUTE_WIDTH-1:0] cmd_route,
  input  logic [LEN_WIDTH-1:0]   cmd_length,
  input  logic                   pld_valid,
  output logic                   pld_ready,
  input  logic [FLIT_WIDTH-2:0]  pld_data,
  output logic                   local_ingress_write,
  output logic [FLIT_WIDTH-1:0]  local_ingress_data,
  input  logic                   local_ingress_full,
  output logic                   busy,
  output logic [15:0]            pkt_count,
  output logic [31:0]            flit_count
);

  generate
    if (ROUTE_WIDTH + LEN_WIDTH > FLIT_WIDTH - 1) begin : g_width_check
      $error("hynoc_local_packetizer: route+length do not fit in flit body");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  // Reset asserts asynchronously and releases two clock edges later.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  state_t                 state;
  logic [ROUTE_WIDTH-1:0] hdr_route;
  logic [LEN_WIDTH-1:0]   hdr_len;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [FLIT_WIDTH-1:0]  hdr_flit;

  // Single FSM: cmd_ready and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      hdr_route <= '0;
      hdr_len   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            hdr_route <= cmd_route;
            hdr_len   <= cmd_length;
            remaining <= cmd_length;
            state     <= HEADER;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        HEADER: begin
          if (!local_ingress_full) begin
            if (hdr_len == '0) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (pld_valid && !local_ingress_full) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Flit selection and write strobe are combinational so payload words pass
  // through with no added latency; full blocks the strobe in the same cycle.
  always_comb begin
    hdr_flit                          = '0;
    hdr_flit[ROUTE_WIDTH-1:0]         = hdr_route;
    hdr_flit[ROUTE_WIDTH +: LEN_WIDTH] = hdr_len;
    hdr_flit[FLIT_WIDTH-1]            = (hdr_len == '0);

    local_ingress_write = 1'b0;
    local_ingress_data  = '0;
    pld_ready           = 1'b0;
    case (state)
      HEADER: begin
        local_ingress_write = !local_ingress_full;
        local_ingress_data  = hdr_flit;
      end
      PAYLOAD: begin
        pld_ready           = !local_ingress_full;
        local_ingress_write = pld_valid && !local_ingress_full;
        local_ingress_data  = {(remaining == LEN_WIDTH'(1)), pld_data};
      end
      default: ;
    endcase
  end

`ifdef HYNOC_PACKETIZER_STATS_EN
  // Both counters wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else if (local_ingress_write) begin
      flit_count <= flit_count + 32'd1;
      if (local_ingress_data[FLIT_WIDTH-1]) pkt_count <= pkt_count + 16'd1;
    end
  end
`else
  assign pkt_count  = '0;
  assign flit_count = '0;
`endif

endmodule

// File: tb/tb_hynoc_local_packetizer.sv
module tb_hynoc_local_packetizer;

  logic        clk = 1'b0;
  logic        arstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_route;
  logic [7:0]  cmd_length;
  logic        pld_valid;
  logic        pld_ready;
  logic [31:0] pld_data;
  logic        local_ingress_write;
  logic [32:0] local_ingress_data;
  logic        local_ingress_full;
  logic        busy;
  logic [15:0] pkt_count;
  logic [31:0] flit_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [32:0] wq[$];
  int          wcyc[$];

  int nf, nc;

  hynoc_local_packetizer dut (
    .clk                 (clk),
    .arstn               (arstn),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_route           (cmd_route),
    .cmd_length          (cmd_length),
    .pld_valid           (pld_valid),
    .pld_ready           (pld_ready),
    .pld_data            (pld_data),
    .local_ingress_write (local_ingress_write),
    .local_ingress_data  (local_ingress_data),
    .local_ingress_full  (local_ingress_full),
    .busy                (busy),
    .pkt_count           (pkt_count),
    .flit_count          (flit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every flit write in the middle of the cycle.
  always @(negedge clk) begin
    if (local_ingress_write) begin
      wq.push_back(local_ingress_data);
      wcyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 10 && !cmd_ready; n++) step();
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
  endtask

  // Issues one command and drives the payload stream; vpat/fpat give
  // pld_valid and full per cycle, counted from the header cycle.
  task automatic send_pkt(input logic [15:0] route, input logic [7:0] len,
                          input logic [31:0] base, input logic [63:0] vpat,
                          input logic [63:0] fpat, output int fires, output int cycles);
    int k = 0;
    int i = 0;
    int nw = 0;
    logic fire;
    logic [32:0] exp_d;
    wq.delete();
    wcyc.delete();
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_route  = route;
    cmd_length = len;
    step();
    cmd_valid = 1'b0;
    do begin
      pld_valid          = vpat[i];
      local_ingress_full = fpat[i];
      pld_data           = base + 32'(k);
      @(negedge clk);
      if (local_ingress_full) begin
        chk("stall_write", 64'(local_ingress_write), 64'd0);
        chk("stall_pld_ready", 64'(pld_ready), 64'd0);
        if (nw == 0) exp_d = {(len == 8'd0), 8'h00, len, route};
        else         exp_d = {(32'(k) == 32'(len) - 1), base + 32'(k)};
        chk("stall_data", 64'(local_ingress_data), 64'(exp_d));
      end
      fire = pld_valid && pld_ready;
      if (local_ingress_write) nw++;
      step();
      if (fire) k++;
      i++;
    end while (busy && i < 60);
    if (busy) chk("pkt_timeout", 64'(busy), 64'd0);
    pld_valid          = 1'b0;
    local_ingress_full = 1'b0;
    fires  = k;
    cycles = i;
  endtask

  initial begin
    arstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_route = '0;
    cmd_length = '0;
    pld_valid = 1'b0;
    pld_data = '0;
    local_ingress_full = 1'b0;
    repeat (3) step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_write", 64'(local_ingress_write), 64'd0);
    chk("rst_pld_ready", 64'(pld_ready), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_flit_count", 64'(flit_count), 64'd0);
    arstn = 1'b1;
    wait_ready();

    // Length 3, payload always valid.
    send_pkt(16'h00A5, 8'd3, 32'd1, '1, '0, nf, nc);
    chk("t1_nwrites", 64'(wq.size()), 64'd4);
    chk("t1_hdr", 64'(wq[0]), 64'h0_0003_00A5);
    chk("t1_p0", 64'(wq[1]), 64'h0_0000_0001);
    chk("t1_p1", 64'(wq[2]), 64'h0_0000_0002);
    chk("t1_p2_tail", 64'(wq[3]), 64'h1_0000_0003);
    chk("t1_consecutive", 64'(wcyc[3] - wcyc[0]), 64'd3);
    chk("t1_cycles", 64'(nc), 64'd4);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Header-only packet.
    send_pkt(16'h1234, 8'd0, 32'h0, '1, '0, nf, nc);
    chk("t2_nwrites", 64'(wq.size()), 64'd1);
    chk("t2_hdr", 64'(wq[0]), 64'h1_0000_1234);
    chk("t2_cycles", 64'(nc), 64'd1);
    chk("t2_no_pld", 64'(nf), 64'd0);

    // Full held high for 5 cycles in PAYLOAD.
    send_pkt(16'h0042, 8'd2, 32'h10, '1, 64'h3E, nf, nc);
    chk("t3_nwrites", 64'(wq.size()), 64'd3);
    chk("t3_hdr", 64'(wq[0]), 64'h0_0002_0042);
    chk("t3_p0", 64'(wq[1]), 64'h0_0000_0010);
    chk("t3_p1_tail", 64'(wq[2]), 64'h1_0000_0011);
    chk("t3_fires", 64'(nf), 64'd2);
    chk("t3_cycles", 64'(nc), 64'd8);

    // pld_valid 1,0,1.
    send_pkt(16'h0007, 8'd2, 32'h20, 64'hB, '0, nf, nc);
    chk("t4_nwrites", 64'(wq.size()), 64'd3);
    chk("t4_p0", 64'(wq[1]), 64'h0_0000_0020);
    chk("t4_p1_tail", 64'(wq[2]), 64'h1_0000_0021);
    chk("t4_gap", 64'(wcyc[2] - wcyc[1]), 64'd2);
    chk("t4_cycles", 64'(nc), 64'd4);

    // Reset in the middle of a length-5 payload.
    chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_route  = 16'h0055;
    cmd_length = 8'd5;
    step();
    cmd_valid = 1'b0;
    pld_valid = 1'b1;
    pld_data  = 32'h99;
    step();
    step();
    chk("t5_mid_busy", 64'(busy), 64'd1);
    chk("t5_mid_write", 64'(local_ingress_write), 64'd1);
    #2;
    arstn = 1'b0;
    #1;
    chk("t5_async_busy", 64'(busy), 64'd0);
    chk("t5_async_write", 64'(local_ingress_write), 64'd0);
    chk("t5_async_pld_ready", 64'(pld_ready), 64'd0);
    chk("t5_async_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("t5_async_pkt_count", 64'(pkt_count), 64'd0);
    chk("t5_async_flit_count", 64'(flit_count), 64'd0);
    pld_valid = 1'b0;
    step();
    step();
    arstn = 1'b1;
    wait_ready();

    // Lengths 0, 1, 4 after reset; the first payload packet checks a clean header.
    send_pkt(16'h0101, 8'd0, 32'h0, '1, '0, nf, nc);
    chk("t6_hdr0", 64'(wq[0]), 64'h1_0000_0101);
    send_pkt(16'hBEEF, 8'd1, 32'h77, '1, '0, nf, nc);
    chk("t6_clean_hdr", 64'(wq[0]), 64'h0_0001_BEEF);
    chk("t6_p_tail", 64'(wq[1]), 64'h1_0000_0077);
    send_pkt(16'h0202, 8'd4, 32'h30, '1, '0, nf, nc);
    chk("t6_nwrites", 64'(wq.size()), 64'd5);
    chk("t6_last_tail", 64'(wq[4]), 64'h1_0000_0033);
`ifdef HYNOC_PACKETIZER_STATS_EN
    chk("stats_pkt_count", 64'(pkt_count), 64'd3);
    chk("stats_flit_count", 64'(flit_count), 64'd8);
`else
    chk("stats_pkt_count", 64'(pkt_count), 64'd0);
    chk("stats_flit_count", 64'(flit_count), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
